// File: rtl/datapath.sv
// datapath -- accumulator-machine datapath: 32x8 program/data memory with a
// registered read port, instruction register, 5-bit program counter,
// 8-bit accumulator with add/subtract, and a sticky halt flag.
// Optional feature: define DATAPATH_OVF_EN to add the Ovf output, which
// records signed overflow of the last adder result loaded into A.
// There is no FSM here; sequencing comes from the external control unit.
// Control strobes are sampled only on the rising Clock edge; every output
// comes from a register (flags are decoded from the A register only).
module datapath (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       IRload,
    input  logic       PCload,
    input  logic       JMPmux,
    input  logic       Meminst,
    input  logic       MemWr,
    input  logic       Aload,
    input  logic       Sub,
    input  logic       Halt,
    input  logic [1:0] Asel,
    input  logic [7:0] DataIn,
    input  logic       ProgWe,
    input  logic [4:0] ProgAddr,
    input  logic [7:0] ProgData,
    output logic [7:0] IR,
    output logic       Aeq0,
    output logic       Apos,
    output logic [7:0] Aout,
    output logic [4:0] PCout,
    output logic       Halted
`ifdef DATAPATH_OVF_EN
    ,
    output logic       Ovf
`endif
);

    logic [7:0] mem [32];
    logic [7:0] memq;
    logic [4:0] pc;
    logic [7:0] a;
    logic       halted;
    logic [4:0] addr;
    logic [7:0] sum;
    logic       frozen;
`ifdef DATAPATH_OVF_EN
    logic       sum_ovf;
`endif

    // Address selection, adder/subtractor and freeze decode.
    always_comb begin
        addr   = Meminst ? IR[4:0] : pc;
        sum    = Sub ? (a - memq) : (a + memq);
        frozen = Halt | halted;
    end

`ifdef DATAPATH_OVF_EN
    // Signed overflow: add overflows when operands share a sign that the
    // result lacks; subtract when operand signs differ and the result's
    // sign departs from A.
    always_comb begin
        sum_ovf = 1'b0;
        if (Sub)
            sum_ovf = (a[7] != memq[7]) && (sum[7] != a[7]);
        else
            sum_ovf = (a[7] == memq[7]) && (sum[7] != a[7]);
    end
`endif

    // Memory array: never cleared; writes are dropped while in reset or frozen.
    // ProgWe is applied last so it wins an address collision with MemWr.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (Reset_n && !frozen) begin
            if (MemWr)
                mem[addr] <= a;
            if (ProgWe)
                mem[ProgAddr] <= ProgData;
        end
    end

    // Registered read port: captures the old contents (read-before-write),
    // keeps updating even while halted.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            memq <= 8'h00;
        else
            memq <= mem[addr];
    end

    // Instruction register, program counter and accumulator.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            IR <= 8'h00;
            pc <= 5'd0;
            a  <= 8'h00;
        end else if (!frozen) begin
            if (IRload)
                IR <= memq;
            if (PCload)
                pc <= JMPmux ? IR[4:0] : (pc + 5'd1);
            if (Aload) begin
                case (Asel)
                    2'b00:   a <= sum;
                    2'b01:   a <= DataIn;
                    2'b10:   a <= memq;
                    default: a <= 8'h00;
                endcase
            end
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            halted <= 1'b0;
        else if (Halt)
            halted <= 1'b1;
    end

`ifdef DATAPATH_OVF_EN
    // Overflow flag follows adder loads, clears on other loads, else holds.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            Ovf <= 1'b0;
        else if (!frozen && Aload)
            Ovf <= (Asel == 2'b00) ? sum_ovf : 1'b0;
    end
`endif

    // Output decode from the A register.
    always_comb begin
        Aout   = a;
        PCout  = pc;
        Halted = halted;
        Aeq0   = (a == 8'h00);
        Apos   = (a != 8'h00) && !a[7];
    end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- randomized and directed bench for datapath with a
// behavioural model of the architectural state.
module tb_datapath;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_load = 0, pc_load = 0, jmp_mux = 0, mem_inst = 0, mem_wr = 0;
    logic       a_load = 0, sub = 0, halt = 0, prog_we = 0;
    logic [1:0] a_sel = 0;
    logic [7:0] data_in = 0, prog_data = 0;
    logic [4:0] prog_addr = 0;
    logic [7:0] ir, aout;
    logic [4:0] pc_out;
    logic       aeq0, apos, halted;
`ifdef DATAPATH_OVF_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [7:0] m_mem [32];
    logic [7:0] m_memq = 0, m_ir = 0, m_a = 0;
    logic [4:0] m_pc = 0;
    logic       m_halted = 0, m_ovf = 0;

    datapath dut (
        .Clock(clk), .Reset_n(rst_n),
        .IRload(ir_load), .PCload(pc_load), .JMPmux(jmp_mux), .Meminst(mem_inst),
        .MemWr(mem_wr), .Aload(a_load), .Sub(sub), .Halt(halt),
        .Asel(a_sel), .DataIn(data_in),
        .ProgWe(prog_we), .ProgAddr(prog_addr), .ProgData(prog_data),
        .IR(ir), .Aeq0(aeq0), .Apos(apos), .Aout(aout), .PCout(pc_out), .Halted(halted)
`ifdef DATAPATH_OVF_EN
        , .Ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        ir_load = 0; pc_load = 0; jmp_mux = 0; mem_inst = 0; mem_wr = 0;
        a_load = 0; sub = 0; halt = 0; prog_we = 0; a_sel = 0;
    endtask

    // Advance the model by the rules for the current inputs, then clock the DUT.
    task automatic tick();
        logic [4:0] addr;
        logic [7:0] n_memq, n_ir, n_a;
        logic [4:0] n_pc;
        logic       n_ovf;
        int         s;
        if (rst_n) begin
            addr   = mem_inst ? m_ir[4:0] : m_pc;
            n_memq = m_mem[addr];
            n_ir = m_ir; n_pc = m_pc; n_a = m_a; n_ovf = m_ovf;
            if (!(halt || m_halted)) begin
                if (ir_load) n_ir = m_memq;
                if (pc_load) n_pc = jmp_mux ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
                if (a_load) begin
                    if (a_sel == 2'd0) begin
                        s = sub ? int'($signed(m_a)) - int'($signed(m_memq))
                                : int'($signed(m_a)) + int'($signed(m_memq));
                        n_a = 8'(s);
                        n_ovf = (s > 127) || (s < -128);
                    end else begin
                        n_a = (a_sel == 2'd1) ? data_in : (a_sel == 2'd2) ? m_memq : 8'h00;
                        n_ovf = 1'b0;
                    end
                end
                if (mem_wr) m_mem[addr] = m_a;
                if (prog_we) m_mem[prog_addr] = prog_data;
            end
            m_halted = m_halted | halt;
            m_memq = n_memq; m_ir = n_ir; m_pc = n_pc; m_a = n_a; m_ovf = n_ovf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_memq = 0; m_ir = 0; m_pc = 0; m_a = 0; m_halted = 0; m_ovf = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        n_vec++; if (aout !== 8'h00) begin n_err++; $display("FAIL reset_a got %h exp 00", aout); end
        n_vec++; if (pc_out !== 5'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", pc_out); end
        n_vec++; if (ir !== 8'h00) begin n_err++; $display("FAIL reset_ir got %h exp 00", ir); end
        n_vec++; if ({aeq0, apos, halted} !== 3'b100) begin n_err++; $display("FAIL reset_flags got %b exp 100", {aeq0, apos, halted}); end
        rst_n = 1;
    endtask

    // Fill every memory location with random data through the program port.
    task automatic test_load_memory();
        idle();
        for (int i = 0; i < 32; i++) begin
            prog_we = 1; prog_addr = 5'(i); prog_data = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        n_vec++; if (pc_out !== 5'd0) begin n_err++; $display("FAIL load_pc got %0d exp 0", pc_out); end
    endtask

    task automatic test_fetch_load();
        idle(); prog_we = 1; prog_addr = 0; prog_data = 8'h05; tick();
        prog_addr = 5; prog_data = 8'h7F; tick();
        idle(); tick();
        ir_load = 1; pc_load = 1; tick();
        n_vec++; if (ir !== 8'h05) begin n_err++; $display("FAIL fetch_ir got %h exp 05", ir); end
        n_vec++; if (pc_out !== 5'd1) begin n_err++; $display("FAIL fetch_pc got %0d exp 1", pc_out); end
        idle(); mem_inst = 1; tick();
        a_sel = 2'b10; a_load = 1; tick();
        n_vec++; if (aout !== 8'h7F) begin n_err++; $display("FAIL fetch_a got %h exp 7f", aout); end
        n_vec++; if ({aeq0, apos} !== 2'b01) begin n_err++; $display("FAIL fetch_flags got %b exp 01", {aeq0, apos}); end
    endtask

    task automatic test_add_overflow();
        idle(); prog_we = 1; prog_addr = 1; prog_data = 8'h01; tick();
        idle(); tick();
        a_sel = 2'b00; a_load = 1; tick();
        idle();
        n_vec++; if (aout !== 8'h80) begin n_err++; $display("FAIL add_a got %h exp 80", aout); end
        n_vec++; if ({aeq0, apos} !== 2'b00) begin n_err++; $display("FAIL add_flags got %b exp 00", {aeq0, apos}); end
`ifdef DATAPATH_OVF_EN
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL add_ovf got %b exp 1", ovf); end
`endif
    endtask

    task automatic test_subtract_zero();
        idle(); prog_we = 1; prog_addr = 1; prog_data = 8'h05;
        a_load = 1; a_sel = 2'b01; data_in = 8'h05; tick();
        idle(); tick();
        sub = 1; a_sel = 2'b00; a_load = 1; tick();
        idle();
        n_vec++; if (aout !== 8'h00) begin n_err++; $display("FAIL sub_a got %h exp 00", aout); end
        n_vec++; if ({aeq0, apos} !== 2'b10) begin n_err++; $display("FAIL sub_flags got %b exp 10", {aeq0, apos}); end
    endtask

    task automatic test_jump_wrap();
        idle(); prog_we = 1; prog_addr = 1; prog_data = 8'hA9; tick();
        idle(); tick();
        ir_load = 1; tick();
        idle(); jmp_mux = 1; pc_load = 1; tick();
        n_vec++; if (pc_out !== 5'd9) begin n_err++; $display("FAIL jump_pc got %0d exp 9", pc_out); end
        idle(); prog_we = 1; prog_addr = 9; prog_data = 8'hFF; tick();
        idle(); tick();
        ir_load = 1; tick();
        idle(); jmp_mux = 1; pc_load = 1; tick();
        n_vec++; if (pc_out !== 5'd31) begin n_err++; $display("FAIL jump31_pc got %0d exp 31", pc_out); end
        idle(); pc_load = 1; tick();
        idle();
        n_vec++; if (pc_out !== 5'd0) begin n_err++; $display("FAIL wrap_pc got %0d exp 0", pc_out); end
    endtask

    task automatic test_write_collision();
        idle(); prog_we = 1; prog_addr = 0; prog_data = 8'h04;
        a_load = 1; a_sel = 2'b01; data_in = 8'h33; tick();
        idle(); tick();
        ir_load = 1; tick();
        idle(); mem_inst = 1; mem_wr = 1; prog_we = 1; prog_addr = 4; prog_data = 8'h55; tick();
        idle(); mem_inst = 1; tick();
        a_sel = 2'b10; a_load = 1; tick();
        idle();
        n_vec++; if (aout !== 8'h55) begin n_err++; $display("FAIL collide_mem4 got %h exp 55", aout); end
    endtask

    task automatic test_random();
        logic [4:0] cur;
        for (int i = 0; i < 300; i++) begin
            idle();
            ir_load  = 1'($urandom_range(0, 1));
            pc_load  = 1'($urandom_range(0, 1));
            jmp_mux  = 1'($urandom_range(0, 1));
            mem_inst = 1'($urandom_range(0, 1));
            a_load   = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            a_sel    = 2'($urandom_range(0, 3));
            data_in  = 8'($urandom_range(0, 255));
            mem_wr   = ($urandom_range(0, 3) == 0);
            prog_we  = ($urandom_range(0, 3) == 0);
            cur      = mem_inst ? m_ir[4:0] : m_pc;
            prog_addr = ($urandom_range(0, 1) == 1) ? cur : 5'($urandom_range(0, 31));
            prog_data = 8'($urandom_range(0, 255));
            tick();
            n_vec++; if (aout !== m_a) begin n_err++; $display("FAIL rnd_a cyc %0d got %h exp %h", i, aout, m_a); end
            n_vec++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %0d exp %0d", i, pc_out, m_pc); end
            n_vec++; if (ir !== m_ir) begin n_err++; $display("FAIL rnd_ir cyc %0d got %h exp %h", i, ir, m_ir); end
            n_vec++; if ({aeq0, apos} !== {m_a == 8'h00, (m_a != 8'h00) && (m_a < 8'h80)}) begin
                n_err++; $display("FAIL rnd_flags cyc %0d got %b a %h", i, {aeq0, apos}, m_a); end
`ifdef DATAPATH_OVF_EN
            n_vec++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, ovf, m_ovf); end
`endif
        end
        idle();
    endtask

    task automatic test_halt_reset();
        logic [7:0] a_before, pc_before;
        logic [7:0] mem0;
        // Known memory and pointer state before halting.
        idle(); prog_we = 1; prog_addr = 0; prog_data = 8'h04;
        a_load = 1; a_sel = 2'b01; data_in = 8'h55; tick();
        idle();
        a_before = aout; pc_before = 8'(pc_out); mem0 = m_mem[0];
        halt = 1; a_load = 1; a_sel = 2'b01; data_in = 8'hAA;
        prog_we = 1; prog_addr = 0; prog_data = 8'hEE; tick();
        n_vec++; if (aout !== 8'h55) begin n_err++; $display("FAIL halt_a got %h exp 55", aout); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got %b exp 1", halted); end
        idle(); pc_load = 1; ir_load = 1; a_load = 1; a_sel = 2'b11; tick();
        n_vec++; if ({aout, 3'b000, pc_out} !== {a_before, pc_before}) begin
            n_err++; $display("FAIL halted_hold got %h/%0d exp %h/%0d", aout, pc_out, a_before, pc_before); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky got %b exp 1", halted); end
        idle();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_vec++; if ({halted, pc_out, aout, ir} !== 22'd0) begin
            n_err++; $display("FAIL async_reset got h%b pc%0d a%h ir%h exp all 0", halted, pc_out, aout, ir); end
        // Write during reset must be discarded.
        prog_we = 1; prog_addr = 0; prog_data = 8'hEE;
        tick();
        idle(); #2; rst_n = 1;
        @(posedge clk); #1;
        a_sel = 2'b10; a_load = 1; tick();
        idle();
        n_vec++; if (aout !== 8'h04) begin n_err++; $display("FAIL mem_persist got %h exp 04", aout); end
        n_vec++; if (mem0 !== 8'h04) begin n_err++; $display("FAIL model_mem0 got %h exp 04", mem0); end
    endtask

    initial begin
        test_reset();
        test_load_memory();
        test_fetch_load();
        test_add_overflow();
        test_subtract_zero();
        test_jump_wrap();
        test_write_collision();
        test_random();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001: Clock  in  1  single system clock; all state updates on its rising edge.
REQ-002: Reset_n  in  1  asynchronous, active-low reset.
REQ-003: IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt  in  1 each  control strobes from the control unit.
REQ-004: Asel  in  2  accumulator source select: 00 adder/subtractor, 01 DataIn, 10 memory read data, 11 constant 0.
REQ-005: DataIn  in  8  external input value for the Input instruction.
REQ-006: ProgWe  in  1, ProgAddr  in  5, ProgData  in  8  program-load write port into instruction/data memory.
REQ-007: IR  out  8  instruction register; IR[7:5] opcode, IR[4:0] operand address.
REQ-008: Aeq0  out  1  high when A == 8'h00; Apos  out  1  high when A[7]==0 and A != 0.
REQ-009: Aout  out  8  accumulator value; PCout  out  5  program counter value; Halted  out  1  halt flag.

Function
REQ-010: Memory: 32 x 8 register array, single address, synchronous read; read data register MemQ captures mem[addr] every clock edge.
REQ-011: Address mux: addr = PC when Meminst=0, IR[4:0] when Meminst=1.
REQ-012: Read latency: MemQ is valid one cycle after the address is presented; same-cycle write to the read address returns old data (read-before-write).
REQ-013: MemWr=1: mem[addr] <= A at the clock edge.
REQ-014: ProgWe=1: mem[ProgAddr] <= ProgData; when ProgWe and MemWr target the same address in one cycle, ProgData wins; different addresses both write.
REQ-015: IRload=1: IR <= MemQ.
REQ-016: PCload=1 and JMPmux=0: PC <= PC+1, 5-bit wrap (31 -> 0); PCload=1 and JMPmux=1: PC <= IR[4:0].
REQ-017: Adder: Sum = A + MemQ when Sub=0, A - MemQ when Sub=1; 8-bit modulo result, carry discarded.
REQ-018: Aload=1: A <= source selected by Asel (REQ-004).
REQ-019: Aeq0 and Apos are combinational from the A register, not from the A input mux.
REQ-020: Halt=1: Halted <= 1 (sticky until reset); while Halt=1 or Halted=1, IR, PC, A and memory writes (MemWr and ProgWe) are suppressed; MemQ keeps updating.
REQ-021: Simultaneous IRload and PCload in one cycle are legal; IR takes the MemQ value and PC advances independently.
REQ-022: Control inputs are sampled only at the clock edge; no combinational path from control inputs to outputs except through registers.

Reset
REQ-023: Reset_n low asynchronously forces PC=0, IR=0, A=0, MemQ=0, Halted=0 (and Ovf=0 when present); outputs reflect this without waiting for a clock edge.
REQ-024: Memory contents are not cleared by reset; the contents written before reset persist.
REQ-025: Reset asserted mid-instruction aborts it; a write whose edge coincides with Reset_n low is discarded.
REQ-026: After Reset_n deasserts, the first edge presents PC=0 to memory.

Configuration
REQ-027: Macro DATAPATH_OVF_EN defined: add output Ovf (1 bit); on Aload with Asel=00, Ovf <= signed two's-complement overflow of the add or subtract; on Aload with any other Asel, Ovf <= 0; otherwise Ovf holds.
REQ-028: DATAPATH_OVF_EN undefined: the Ovf port and its logic are absent; all other behaviour is identical.

Verification
REQ-029: ProgWe mem[0]=8'h05, mem[5]=8'h7F; Meminst=0 for 1 cycle; IRload=PCload=1 -> IR=8'h05, PC=1; Meminst=1 for 1 cycle; Asel=10, Aload=1 -> A=8'h7F, Apos=1, Aeq0=0.
REQ-030: A=8'h7F, MemQ=8'h01, Asel=00, Sub=0, Aload=1 -> A=8'h80, Apos=0, Aeq0=0, Ovf=1 (when DATAPATH_OVF_EN is defined).
REQ-031: A=8'h05, MemQ=8'h05, Sub=1, Asel=00, Aload=1 -> A=8'h00, Aeq0=1, Apos=0.
REQ-032: IR=8'hA9, JMPmux=1, PCload=1 -> PC=9; then PC=31, JMPmux=0, PCload=1 -> PC=0.
REQ-033: A=8'h33, IR[4:0]=4, Meminst=1, MemWr=1, and ProgWe with ProgAddr=4, ProgData=8'h55 in the same cycle -> mem[4]=8'h55.
REQ-034: Halt=1 with Aload=1, DataIn=8'hAA, Asel=01 -> A unchanged, Halted=1; Reset_n low -> Halted=0, PC=0, A=0 immediately, memory unchanged.
